bmd_256_latency_stats: RTL and testbench
========================================

BMD_256_LATENCY_STATS -- requirements
Module: bmd_256_latency_stats

Interface
REQ-001 SHALL have parameter CNT_W, default 40, meaning timestamp/latency width.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning echo tag / BRAM address width.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning BRAM port-B read latency in cycles (1..4).
REQ-004 SHALL have parameter HIST_SHIFT, default 4, meaning histogram bin granularity of 2^HIST_SHIFT cycles.
REQ-005 SHALL have the ports below (clock and reset first):
clk  in  1  single 250 MHz clock; one clock domain; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
latency_reset_signal  in  1  synchronous user clear of statistics and in-flight measurement
latency_counter  in  CNT_W  free-running time base
echo_valid  in  1  echo packet arrived from RX engine
echo_tag  in  ADDR_W  BRAM address holding this echo's send timestamp
echo_ready  out  1  block can accept an echo
bram_reb  out  1  timestamp BRAM read enable
bram_rd_addr  out  ADDR_W  timestamp BRAM read address
bram_rd_data  in  CNT_W  timestamp BRAM read data
lat_valid  out  1  one-cycle pulse: lat_value valid
lat_value  out  CNT_W  latest measured latency
lat_min  out  CNT_W  minimum latency since clear
lat_max  out  CNT_W  maximum latency since clear
lat_sum  out  CNT_W+16  saturating sum of latencies
lat_count  out  32  saturating sample count
lat_sat  out  1  sticky: lat_sum or lat_count saturated
hist_counts  out  8*16  eight 16-bit histogram bins, bin 0 in LSBs

Function
REQ-006 FSM states SHALL be IDLE, RD, WAIT, CALC.
REQ-007 echo_ready SHALL be 1 only in IDLE.
REQ-008 On echo_valid&&echo_ready at edge T: capture echo_tag and latency_counter (arrival time), go to RD.
REQ-009 In RD and WAIT, bram_reb SHALL be 1 and bram_rd_addr SHALL equal the captured tag; bram_reb SHALL be 0 in IDLE and CALC.
REQ-010 WAIT SHALL last RD_LAT cycles; bram_rd_data is sampled on the final WAIT edge; then CALC.
REQ-011 CALC SHALL compute latency = (arrival - stamp) mod 2^CNT_W, so counter wrap yields the correct positive value.
REQ-012 lat_valid SHALL pulse for exactly one cycle, RD_LAT+3 cycles after the accept edge (cycle T+5 at RD_LAT=2); lat_value is updated in the same cycle and is held until the next result.
REQ-013 In the lat_valid cycle: lat_min/lat_max are updated by compare; lat_sum += latency, saturating at all-ones; lat_count += 1, saturating at 2^32-1; lat_sat is set on either saturation.
REQ-014 The FSM SHALL return to IDLE after CALC; back-to-back throughput is one echo per RD_LAT+3 cycles.
REQ-015 latency_reset_signal SHALL take priority over all activity: FSM to IDLE, no lat_valid for an aborted measurement, lat_min = all-ones, lat_max/lat_sum/lat_count/lat_sat/hist = 0, lat_value = 0.
REQ-016 echo_valid held while echo_ready=0 SHALL NOT be consumed.

Reset
REQ-017 On rst_n=0, all outputs and state SHALL assume the REQ-015 clear values; echo_ready = 1 (IDLE) and bram_reb = 0.
REQ-018 Reset SHALL take effect asynchronously; release is synchronous to clk.

Configuration
REQ-019 Macro BMD_LATENCY_HIST_EN, when defined: bin = min(latency >> HIST_SHIFT, 7), incremented in the lat_valid cycle, saturating at 0xFFFF.
REQ-020 Without BMD_LATENCY_HIST_EN: hist_counts SHALL be constant 0 and no histogram registers are built; all other behaviour is identical.

Structure
REQ-021 Package bmd_latency_pkg SHALL hold CNT_W/ADDR_W defaults, the FSM state encoding, and the bin count (8) and bin width (16).
REQ-022 The histogram SHALL be sub-module bmd_latency_hist (latency, strobe, clear in; hist_counts out), instantiated only under the macro.

Verification
REQ-023 Stamp 100 at tag 5; echo at counter 350 -> lat_value = 250, lat_valid at T+5, min = max = 250, count = 1.
REQ-024 Stamp 0xFF_FFFF_FFF0 at tag 0; arrival counter 0x10 -> lat_value = 0x20 (wrap).
REQ-025 Latencies 30, 10, 50 in sequence -> min = 10, max = 50, sum = 90, count = 3; echo_valid held high is accepted only in IDLE, with accepts spaced 5 cycles apart.
REQ-026 latency_reset_signal pulsed during WAIT -> no lat_valid; min = all-ones; echo_ready = 1 on the next cycle.
REQ-027 With macro defined and HIST_SHIFT = 4: latencies 5, 20, 200 -> bins 0, 1, 7 each = 1; without the macro -> hist_counts = 0.
REQ-028 Force lat_count to 0xFFFF_FFFF and add one sample -> lat_count holds at 0xFFFF_FFFF and lat_sat = 1.

Source files
------------

// File: rtl/bmd_latency_pkg.sv
// Shared definitions for the BMD echo latency statistics block: default widths,
// FSM state encoding and histogram geometry.
package bmd_latency_pkg;

    localparam int CNT_W_DEF  = 40;
    localparam int ADDR_W_DEF = 13;
    localparam int HIST_BINS  = 8;
    localparam int HIST_BIN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        CALC = 2'd3
    } lat_state_t;

endpackage

// File: rtl/bmd_latency_hist.sv
// Latency histogram: eight saturating 16-bit bins of 2^HIST_SHIFT cycles each,
// the last bin collecting everything beyond the range of the others.
module bmd_latency_hist
    import bmd_latency_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HIST_SHIFT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CNT_W-1:0]                 latency,
    input  logic                             strobe,
    input  logic                             clear,
    output logic [HIST_BINS*HIST_BIN_W-1:0]  hist_counts
);

    logic [CNT_W-1:0]      shifted;
    logic [2:0]            bin;
    logic [HIST_BIN_W-1:0] bin_cnt;

    always_comb begin
        shifted = latency >> HIST_SHIFT;
        bin     = (shifted > CNT_W'(HIST_BINS - 1)) ? 3'(HIST_BINS - 1) : shifted[2:0];
        bin_cnt = hist_counts[int'(bin)*HIST_BIN_W +: HIST_BIN_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_counts <= '0;
        end else if (clear) begin
            hist_counts <= '0;
        end else if (strobe && (bin_cnt != '1)) begin
            hist_counts[int'(bin)*HIST_BIN_W +: HIST_BIN_W] <= bin_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bmd_256_latency_stats.sv
// Echo round-trip latency measurement: fetches the send timestamp from BRAM,
// subtracts it from the arrival time and keeps min/max/sum/count statistics.
// Optional histogram enabled by defining BMD_LATENCY_HIST_EN.
module bmd_256_latency_stats
    import bmd_latency_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_LAT     = 2,
    parameter int HIST_SHIFT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             latency_reset_signal,
    input  logic [CNT_W-1:0]                 latency_counter,
    input  logic                             echo_valid,
    input  logic [ADDR_W-1:0]                echo_tag,
    output logic                             echo_ready,
    output logic                             bram_reb,
    output logic [ADDR_W-1:0]                bram_rd_addr,
    input  logic [CNT_W-1:0]                 bram_rd_data,
    output logic                             lat_valid,
    output logic [CNT_W-1:0]                 lat_value,
    output logic [CNT_W-1:0]                 lat_min,
    output logic [CNT_W-1:0]                 lat_max,
    output logic [CNT_W+15:0]                lat_sum,
    output logic [31:0]                      lat_count,
    output logic                             lat_sat,
    output logic [HIST_BINS*HIST_BIN_W-1:0]  hist_counts
);

    localparam int SUM_W = CNT_W + 16;

    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W:0] s);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [31:0] sat_cnt(input logic [32:0] c);
        return c[32] ? '1 : c[31:0];
    endfunction

    lat_state_t        state;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] tag_p0;
    logic [CNT_W-1:0]  arrival_p0;
    logic [CNT_W-1:0]  stamp_p1;
    logic [CNT_W-1:0]  latency_p2;
    logic [SUM_W:0]    sum_ext_p2;
    logic [32:0]       cnt_ext_p2;

    // Modulo subtraction makes a wrapped time base produce the true positive latency.
    always_comb begin
        latency_p2 = arrival_p0 - stamp_p1;
        sum_ext_p2 = {1'b0, lat_sum} + {17'd0, latency_p2};
        cnt_ext_p2 = {1'b0, lat_count} + 33'd1;
    end

    assign bram_rd_addr = tag_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            tag_p0     <= '0;
            arrival_p0 <= '0;
            stamp_p1   <= '0;
            echo_ready <= 1'b1;
            bram_reb   <= 1'b0;
            lat_valid  <= 1'b0;
            lat_value  <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            lat_sum    <= '0;
            lat_count  <= '0;
            lat_sat    <= 1'b0;
        end else if (latency_reset_signal) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            echo_ready <= 1'b1;
            bram_reb   <= 1'b0;
            lat_valid  <= 1'b0;
            lat_value  <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            lat_sum    <= '0;
            lat_count  <= '0;
            lat_sat    <= 1'b0;
        end else begin
            lat_valid <= 1'b0;
            case (state)
                // IDLE -> RD: capture tag and arrival time
                IDLE: begin
                    if (echo_valid) begin
                        tag_p0     <= echo_tag;
                        arrival_p0 <= latency_counter;
                        echo_ready <= 1'b0;
                        bram_reb   <= 1'b1;
                        state      <= RD;
                    end
                end
                RD: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                // WAIT -> CALC: stamp sampled on the last read-latency edge
                WAIT: begin
                    if (wait_cnt == 2'(RD_LAT - 1)) begin
                        stamp_p1 <= bram_rd_data;
                        bram_reb <= 1'b0;
                        state    <= CALC;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // CALC -> IDLE: publish result and fold into statistics
                CALC: begin
                    lat_valid  <= 1'b1;
                    lat_value  <= latency_p2;
                    if (latency_p2 < lat_min) lat_min <= latency_p2;
                    if (latency_p2 > lat_max) lat_max <= latency_p2;
                    lat_sum    <= sat_sum(sum_ext_p2);
                    lat_count  <= sat_cnt(cnt_ext_p2);
                    if (sum_ext_p2[SUM_W] || cnt_ext_p2[32]) lat_sat <= 1'b1;
                    echo_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BMD_LATENCY_HIST_EN
    bmd_latency_hist #(
        .CNT_W      (CNT_W),
        .HIST_SHIFT (HIST_SHIFT)
    ) u_hist (
        .clk         (clk),
        .rst_n       (rst_n),
        .latency     (latency_p2),
        .strobe      ((state == CALC) && !latency_reset_signal),
        .clear       (latency_reset_signal),
        .hist_counts (hist_counts)
    );
`else
    assign hist_counts = '0;
`endif

endmodule

// File: tb/tb_bmd_256_latency_stats.sv
// Directed bench for bmd_256_latency_stats with a small BRAM model (read latency RD_LAT).
module tb_bmd_256_latency_stats;

    localparam int CNT_W  = 40;
    localparam int ADDR_W = 13;
    localparam int RD_LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               latency_reset_signal;
    logic [CNT_W-1:0]   latency_counter;
    logic               echo_valid;
    logic [ADDR_W-1:0]  echo_tag;
    logic               echo_ready;
    logic               bram_reb;
    logic [ADDR_W-1:0]  bram_rd_addr;
    logic [CNT_W-1:0]   bram_rd_data;
    logic               lat_valid;
    logic [CNT_W-1:0]   lat_value;
    logic [CNT_W-1:0]   lat_min;
    logic [CNT_W-1:0]   lat_max;
    logic [CNT_W+15:0]  lat_sum;
    logic [31:0]        lat_count;
    logic               lat_sat;
    logic [127:0]       hist_counts;

    int total = 0;
    int bad   = 0;

    logic [CNT_W-1:0] mem [0:15];
    logic [CNT_W-1:0] rd_pipe;

    always #2 clk = ~clk;

    // Two-stage BRAM read pipeline
    always @(posedge clk) begin
        if (bram_reb) rd_pipe <= mem[bram_rd_addr[3:0]];
        bram_rd_data <= rd_pipe;
    end

    bmd_256_latency_stats #(
        .CNT_W      (CNT_W),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .HIST_SHIFT (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .latency_reset_signal (latency_reset_signal),
        .latency_counter      (latency_counter),
        .echo_valid           (echo_valid),
        .echo_tag             (echo_tag),
        .echo_ready           (echo_ready),
        .bram_reb             (bram_reb),
        .bram_rd_addr         (bram_rd_addr),
        .bram_rd_data         (bram_rd_data),
        .lat_valid            (lat_valid),
        .lat_value            (lat_value),
        .lat_min              (lat_min),
        .lat_max              (lat_max),
        .lat_sum              (lat_sum),
        .lat_count            (lat_count),
        .lat_sat              (lat_sat),
        .hist_counts          (hist_counts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        latency_reset_signal = 1'b1;
        tick();
        latency_reset_signal = 1'b0;
    endtask

    // One echo; lat_valid must be seen 4 edges after the accept edge (the cycle closing at T+5).
    task automatic run_echo(input logic [ADDR_W-1:0] tag, input logic [CNT_W-1:0] ctr,
                            input logic [CNT_W-1:0] exp_lat, input string nm);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        echo_tag        = tag;
        latency_counter = ctr;
        echo_valid      = 1'b1;
        tick();
        echo_valid = 1'b0;
        total++;
        if (bram_reb !== 1'b1 || bram_rd_addr !== tag) begin
            bad++;
            $display("FAIL %s_bram_rd: reb=%0b addr=%0d, need reb=1 addr=%0d", nm, bram_reb, bram_rd_addr, tag);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (lat_valid) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        total++;
        if (first !== 4 || pulses !== 1) begin
            bad++;
            $display("FAIL %s_timing: first=%0d pulses=%0d, need first=4 pulses=1", nm, first, pulses);
        end
        total++;
        if (lat_value !== exp_lat) begin
            bad++;
            $display("FAIL %s_value: got %0h, need %0h", nm, lat_value, exp_lat);
        end
    endtask

    task automatic test_reset();
        total++;
        if (echo_ready !== 1'b1 || bram_reb !== 1'b0 || lat_valid !== 1'b0 || lat_value !== '0 ||
            lat_min !== {CNT_W{1'b1}} || lat_max !== '0 || lat_sum !== '0 || lat_count !== '0 ||
            lat_sat !== 1'b0 || hist_counts !== '0) begin
            bad++;
            $display("FAIL reset_state: ready=%0b reb=%0b vld=%0b min=%0h max=%0h sum=%0h cnt=%0h sat=%0b",
                     echo_ready, bram_reb, lat_valid, lat_min, lat_max, lat_sum, lat_count, lat_sat);
        end
    endtask

    task automatic test_basic();
        clear_stats();
        mem[5] = 40'd100;
        run_echo(13'd5, 40'd350, 40'd250, "basic");
        total++;
        if (lat_min !== 40'd250 || lat_max !== 40'd250 || lat_count !== 32'd1 || lat_sum !== 56'd250) begin
            bad++;
            $display("FAIL basic_stats: min=%0d max=%0d cnt=%0d sum=%0d, need 250 250 1 250",
                     lat_min, lat_max, lat_count, lat_sum);
        end
        total++;
        if (bram_reb !== 1'b0 || echo_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_idle: reb=%0b ready=%0b, need 0 1", bram_reb, echo_ready);
        end
    endtask

    task automatic test_wrap();
        clear_stats();
        mem[0] = 40'hFF_FFFF_FFF0;
        run_echo(13'd0, 40'h10, 40'h20, "wrap");
    endtask

    task automatic test_back_to_back();
        int acc;
        int last;
        logic was_ready;
        clear_stats();
        mem[1] = 40'd970;
        mem[2] = 40'd990;
        mem[3] = 40'd950;
        latency_counter = 40'd1000;
        echo_tag   = 13'd1;
        echo_valid = 1'b1;
        acc  = 0;
        last = 0;
        for (int c = 1; c <= 40 && acc < 3; c++) begin
            was_ready = echo_ready;
            tick();
            if (was_ready) begin
                acc++;
                if (acc > 1) begin
                    total++;
                    if (c - last !== 5) begin
                        bad++;
                        $display("FAIL b2b_gap: accept spacing %0d, need 5", c - last);
                    end
                end
                last     = c;
                echo_tag = 13'(acc + 1);
                if (acc == 3) echo_valid = 1'b0;
            end
        end
        total++;
        if (acc !== 3) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d, need 3", acc);
        end
        repeat (8) tick();
        total++;
        if (lat_min !== 40'd10 || lat_max !== 40'd50 || lat_sum !== 56'd90 || lat_count !== 32'd3) begin
            bad++;
            $display("FAIL b2b_stats: min=%0d max=%0d sum=%0d cnt=%0d, need 10 50 90 3",
                     lat_min, lat_max, lat_sum, lat_count);
        end
    endtask

    task automatic test_clear_in_wait();
        int pulses;
        clear_stats();
        mem[5] = 40'd100;
        run_echo(13'd5, 40'd350, 40'd250, "pre_abort");
        echo_tag        = 13'd5;
        latency_counter = 40'd500;
        echo_valid      = 1'b1;
        tick();
        echo_valid = 1'b0;
        tick();
        latency_reset_signal = 1'b1;
        tick();
        latency_reset_signal = 1'b0;
        total++;
        if (echo_ready !== 1'b1 || bram_reb !== 1'b0 || lat_min !== {CNT_W{1'b1}} || lat_count !== '0 ||
            lat_value !== '0) begin
            bad++;
            $display("FAIL abort_clear: ready=%0b reb=%0b min=%0h cnt=%0d val=%0d, need 1 0 all-ones 0 0",
                     echo_ready, bram_reb, lat_min, lat_count, lat_value);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (lat_valid) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_valid: saw %0d lat_valid pulses, need 0", pulses);
        end
    endtask

    task automatic test_hist();
        clear_stats();
        mem[6] = 40'd995;
        mem[7] = 40'd980;
        mem[8] = 40'd800;
        run_echo(13'd6, 40'd1000, 40'd5,   "hist_a");
        run_echo(13'd7, 40'd1000, 40'd20,  "hist_b");
        run_echo(13'd8, 40'd1000, 40'd200, "hist_c");
        total++;
        if (lat_sum !== 56'd225 || lat_count !== 32'd3) begin
            bad++;
            $display("FAIL hist_stats: sum=%0d cnt=%0d, need 225 3", lat_sum, lat_count);
        end
        total++;
`ifdef BMD_LATENCY_HIST_EN
        if (hist_counts !== {16'd1, 80'd0, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL hist_bins: got %0h, need bins 0,1,7 = 1", hist_counts);
        end
`else
        if (hist_counts !== '0) begin
            bad++;
            $display("FAIL hist_off: got %0h, need 0", hist_counts);
        end
`endif
    endtask

    task automatic test_count_sat();
        clear_stats();
        force dut.lat_count = 32'hFFFF_FFFF;
        #1;
        release dut.lat_count;
        mem[9] = 40'd93;
        run_echo(13'd9, 40'd100, 40'd7, "sat");
        total++;
        if (lat_count !== 32'hFFFF_FFFF || lat_sat !== 1'b1) begin
            bad++;
            $display("FAIL count_sat: cnt=%0h sat=%0b, need ffffffff 1", lat_count, lat_sat);
        end
    endtask

    task automatic test_async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (lat_count !== '0 || lat_sat !== 1'b0 || echo_ready !== 1'b1 || lat_min !== {CNT_W{1'b1}}) begin
            bad++;
            $display("FAIL async_reset: cnt=%0h sat=%0b ready=%0b min=%0h", lat_count, lat_sat, echo_ready, lat_min);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_n                = 1'b0;
        latency_reset_signal = 1'b0;
        latency_counter      = '0;
        echo_valid           = 1'b0;
        echo_tag             = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_clear_in_wait();
        test_hist();
        test_count_sat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
